// File: rtl/signals.sv
// Shared execute-stage types: HI/LO operation encoding and muldiv sequencer state.
// Pure declarations; no timing or flow control of its own.
package signals;

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MADD  = 4'd4,
    MADDU = 4'd5,
    MSUB  = 4'd6,
    MSUBU = 4'd7,
    MTHI  = 4'd8,
    MTLO  = 4'd9
  } muldiv_op_t;

  typedef logic [1:0] muldiv_state_t;

  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_MUL  = 2'd1;
  localparam muldiv_state_t ST_DIV  = 2'd2;
  localparam muldiv_state_t ST_FIX  = 2'd3;

  function automatic logic op_is_signed(input muldiv_op_t o);
    return o inside {MULT, DIV, MADD, MSUB};
  endfunction

  function automatic logic op_is_div(input muldiv_op_t o);
    return o inside {DIV, DIVU};
  endfunction

  function automatic logic op_is_acc(input muldiv_op_t o);
    return o inside {MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic op_is_mul(input muldiv_op_t o);
    return o inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the execute stage and the HI/LO sequencer.
// master = pipeline side, slave = sequencer side.
interface muldiv_sequencer_if;
  import signals::*;

  logic        start;
  muldiv_op_t  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        read_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic        illegal;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, read_req,
    input  busy, stall, done, illegal, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, read_req,
    output busy, stall, done, illegal, hi, lo
  );

endinterface

// File: rtl/divider_core.sv
// Unsigned restoring divider datapath: load primes the shift registers, each step retires one quotient bit.
// 32 steps per divide; no flow control, the caller owns step sequencing.
module divider_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted = {rem_q, quo_q[31]};
  // diff[32] set means the trial subtraction borrowed, so the partial remainder is restored
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (load) begin
      dvs_q <= divisor;
      rem_q <= '0;
      quo_q <= dividend;
    end else if (step) begin
      rem_q <= diff[32] ? shifted[31:0] : diff[31:0];
      quo_q <= {quo_q[30:0], ~diff[32]};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: MTxx in 1 edge, MUL-class 1 busy cycle, DIV-class 33 busy cycles; stall holds upstream while busy.
// Accumulate ops (MADD/MSUB family) exist only when MULDIV_MADD_EN is defined; otherwise they pulse illegal.
module muldiv_sequencer
  import signals::*;
(
  input logic              clk,
  input logic              rst_n,
  muldiv_sequencer_if.slave bus
);

`ifdef MULDIV_MADD_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  muldiv_state_t state_q;
  logic [4:0]    count_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  muldiv_op_t    op_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          illegal_q;

  logic          in_signed;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic          div_load;
  logic [31:0]   quotient;
  logic [31:0]   remainder;
  logic [63:0]   ext_a;
  logic [63:0]   ext_b;
  logic [63:0]   product;
  logic [63:0]   mul_res;
  logic          q_signed;
  logic [31:0]   fix_hi;
  logic [31:0]   fix_lo;

  assign in_signed = op_is_signed(bus.op);
  assign mag_a     = (in_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign mag_b     = (in_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;
  assign div_load  = (state_q == ST_IDLE) && bus.start && !bus.flush && op_is_div(bus.op);

  divider_core u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (state_q == ST_DIV),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // One unsigned 64x64 multiplier; sign-extending the operands gives the signed product mod 2^64
  assign q_signed = op_is_signed(op_q);
  assign ext_a    = q_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b    = q_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product  = ext_a * ext_b;

  always_comb begin
    mul_res = product;
`ifdef MULDIV_MADD_EN
    if (op_q inside {MADD, MADDU}) begin
      mul_res = {hi_q, lo_q} + product;
    end else if (op_q inside {MSUB, MSUBU}) begin
      mul_res = {hi_q, lo_q} - product;
    end
`endif
  end

  always_comb begin
    fix_hi = remainder;
    fix_lo = quotient;
    if (b_q == 32'd0) begin
      fix_hi = a_q;
      fix_lo = 32'hFFFF_FFFF;
    end else if (q_signed) begin
      fix_lo = (a_q[31] ^ b_q[31]) ? -quotient : quotient;
      fix_hi = a_q[31] ? -remainder : remainder;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= MULT;
      hi_q      <= '0;
      lo_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (bus.flush) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              a_q  <= bus.src_a;
              b_q  <= bus.src_b;
              op_q <= bus.op;
              if (bus.op == MTHI) begin
                hi_q <= bus.src_a;
              end else if (bus.op == MTLO) begin
                lo_q <= bus.src_a;
              end else if (op_is_div(bus.op)) begin
                state_q <= ST_DIV;
                count_q <= 5'd31;
              end else if (op_is_acc(bus.op) && !ACC_EN) begin
                illegal_q <= 1'b1;
              end else if (op_is_mul(bus.op)) begin
                state_q <= ST_MUL;
              end
            end
          end
          ST_MUL: begin
            {hi_q, lo_q} <= mul_res;
            state_q      <= ST_IDLE;
          end
          ST_DIV: begin
            count_q <= count_q - 5'd1;
            if (count_q == 5'd0) begin
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.stall   = bus.busy && (bus.start || bus.read_req);
  assign bus.done    = ((state_q == ST_MUL) || (state_q == ST_FIX)) && !bus.flush;
  assign bus.illegal = illegal_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed checks of muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
  import signals::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural meaning of each op, using 64-bit integer arithmetic.
  function automatic void ref_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l,
                                 output logic ill, output int lat);
    longint      sa, sb;
    logic [63:0] ua, ub, p, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {h, l};
    ill = 1'b0;
    lat = 0;
    case (o)
      MTHI: h = a;
      MTLO: l = a;
      MULT: begin p = sa * sb; {h, l} = p; lat = 1; end
      MULTU: begin p = ua * ub; {h, l} = p; lat = 1; end
      MADD, MADDU, MSUB, MSUBU: begin
`ifdef MULDIV_MADD_EN
        p = (o inside {MADD, MSUB}) ? 64'(sa * sb) : ua * ub;
        {h, l} = (o inside {MADD, MADDU}) ? acc + p : acc - p;
        lat = 1;
`else
        ill = 1'b1;
`endif
      end
      DIV, DIVU: begin
        lat = 33;
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else if (o == DIV) begin
          p = sa / sb;
          l = p[31:0];
          p = sa % sb;
          h = p[31:0];
        end else begin
          p = ua / ub;
          l = p[31:0];
          p = ua % ub;
          h = p[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE and check latency, done/illegal pulses and the resulting HI/LO.
  task automatic do_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    logic ill, exp_ill;
    int   lat, busy_n, done_at, done_n;
    ref_op(o, a, b, m_hi, m_lo, exp_ill, lat);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_n = 0; done_at = 0; done_n = 0;
    @(negedge clk);
    ill = bus.illegal;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.done) begin done_n++; done_at = c; end
      if (!bus.busy) break;
      busy_n++;
    end
    check_eq($sformatf("%s_illegal", o.name()), 64'(ill), 64'(exp_ill));
    check_eq($sformatf("%s_busy_cycles", o.name()), 64'(busy_n), 64'(lat));
    check_eq($sformatf("%s_done_cycle", o.name()), 64'(done_at), 64'(lat));
    check_eq($sformatf("%s_done_count", o.name()), 64'(done_n), (lat > 0) ? 64'd1 : 64'd0);
    check_eq($sformatf("%s_hi", o.name()), 64'(bus.hi), 64'(m_hi));
    check_eq($sformatf("%s_lo", o.name()), 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    logic        ill;
    int          lat, bad, dn;
    logic [31:0] sv_hi, sv_lo;
    bus.start = 1'b0; bus.op = MULT; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.read_req = 1'b0;

    #12;
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done_illegal", {62'd0, bus.done, bus.illegal}, 64'd0);
    rst_n = 1'b1;

    do_op(MULT, 32'hFFFF_FFFF, 32'd2);
    check_eq("mult_const", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(MULTU, 32'hFFFF_FFFF, 32'd2);
    check_eq("multu_const", {32'(bus.hi), 32'(bus.lo)}, 64'h0000_0001_FFFF_FFFE);
    do_op(DIV, -32'd7, 32'd2);
    check_eq("div_neg_const", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(DIVU, 32'd5, 32'd0);
    check_eq("divu_zero_const", {32'(bus.hi), 32'(bus.lo)}, 64'h0000_0005_FFFF_FFFF);
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("div_ovf_const", {32'(bus.hi), 32'(bus.lo)}, 64'h0000_0000_8000_0000);

    do_op(MTHI, 32'hFFFF_FFFF, 32'd0);
    do_op(MTLO, 32'hFFFF_FFFF, 32'd0);
    do_op(MADD, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
    check_eq("madd_wrap_const", {32'(bus.hi), 32'(bus.lo)}, 64'd0);
`else
    check_eq("madd_off_const", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // DIV with read_req and a held second start from T+5
    ref_op(DIV, 32'd1000, 32'd7, m_hi, m_lo, ill, lat);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = DIV; bus.src_a = 32'd1000; bus.src_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = MULTU; bus.src_a = 32'd3; bus.src_b = 32'd9; bus.read_req = 1'b1;
    bad = 0;
    for (int c = 5; c <= 34; c++) begin
      @(negedge clk);
      if (bus.stall !== (c <= 33)) bad++;
    end
    check_eq("stall_window_errors", 64'(bad), 64'd0);
    check_eq("stall_t34_busy", 64'(bus.busy), 64'd0);
    check_eq("stall_t34_hi", 64'(bus.hi), 64'(m_hi));
    check_eq("stall_t34_lo", 64'(bus.lo), 64'(m_lo));
    ref_op(MULTU, 32'd3, 32'd9, m_hi, m_lo, ill, lat);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.read_req = 1'b0;
    @(negedge clk);
    check_eq("held_start_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    check_eq("held_start_lo", 64'(bus.lo), 64'(m_lo));
    check_eq("held_start_hi", 64'(bus.hi), 64'(m_hi));

    // Flush at T+10 of a DIV
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = DIV; bus.src_a = 32'd77; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check_eq("flush_div_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    dn = 0;
    @(negedge clk);
    check_eq("flush_div_idle", 64'(bus.busy), 64'd0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check_eq("flush_div_no_done", 64'(dn), 64'd0);
    check_eq("flush_div_hilo", {32'(bus.hi), 32'(bus.lo)}, {m_hi, m_lo});

    // Flush during MUL suppresses the write
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MULT; bus.src_a = 32'd12345; bus.src_b = 32'd678;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    check_eq("flush_mul_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("flush_mul_hilo", {32'(bus.hi), 32'(bus.lo)}, {m_hi, m_lo});

    // start together with flush in IDLE is dropped
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MTHI; bus.src_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check_eq("flush_idle_hi", 64'(bus.hi), 64'(m_hi));

    // Randomized ops from IDLE
    for (int i = 0; i < 60; i++) begin
      do_op(muldiv_op_t'($urandom_range(0, 9)), pick32(), pick32());
    end

    // Reset mid-MUL clears HI/LO asynchronously
    do_op(MTHI, 32'h1234_5678, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MULT; bus.src_a = 32'd99; bus.src_b = 32'd99;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_mul_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'd0);
    check_eq("rst_mid_mul_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_mul_after", {32'(bus.hi), 32'(bus.lo)}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle HI/LO controller for the execute stage. Accepts MULT/DIV/MADD-class and MTHI/MTLO operations issued by the decoded control word, sequences the multiplier and an iterative divider, and owns the HI/LO registers. It raises `stall` to hold the pipeline whenever a younger HI/LO consumer or a new HI/LO producer arrives while an operation is in flight. `flush` cancels in-flight work on exceptions.

## Interface
- No parameters; operand width fixed at 32, HI/LO at 32 each.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue valid; sampled with `op`/`src_a`/`src_b`.
- `op`  in  4  `signals::muldiv_op_t`: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
- `src_a`  in  32  rs value (dividend / multiplicand / MTxx data).
- `src_b`  in  32  rt value (divisor / multiplier).
- `flush`  in  1  cancel in-flight op; HI/LO keep their pre-op values.
- `read_req`  in  1  MFHI/MFLO in execute needs HI/LO this cycle.
- `busy`  out  1  state != IDLE.
- `stall`  out  1  combinational: `busy && (start || read_req)`.
- `done`  out  1  one-cycle pulse in the cycle HI/LO are written by MUL/DIV/ACC.
- `illegal`  out  1  one-cycle pulse when a disabled op is accepted.
- `hi`, `lo`  out  32 each  registered HI/LO.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start`: MTHI/MTLO write `hi`/`lo` at this edge and stay IDLE. Multiply-class ops latch operands and enter MUL. Divide-class ops latch operands, load the divider, set the count to 31, and enter DIV.
- MUL: signed or unsigned 32x32->64 product. MULT/MULTU write {hi,lo}=product. MADD/MADDU write {hi,lo}+product. MSUB/MSUBU write {hi,lo}-product. All arithmetic is 64-bit modulo 2^64. The block pulses `done` and returns to IDLE.
- DIV: one restoring step per cycle on operand magnitudes; the count decrements; at count 0 the block goes to FIX.
- FIX: signed divide applies the result signs. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign. The block writes lo=quotient, hi=remainder, pulses `done`, and returns to IDLE.
- Divide by zero (`src_b`==0 latched): FIX writes hi=`src_a`, lo=32'hFFFF_FFFF, regardless of signedness.
- 32'h8000_0000 / 32'hFFFF_FFFF (DIV): lo=32'h8000_0000, hi=0.
- `start` while busy is ignored. `stall` holds the pipeline, so upstream keeps `start` high until IDLE.
- `flush` in any state: next state IDLE, no `done`, HI/LO unchanged. A `start` in the same cycle as `flush` is dropped, including in IDLE.
- `flush` has priority over completion: if asserted in MUL or FIX, that write is suppressed.
- Reset: state IDLE, hi=lo=0, done=illegal=0, count=0. Reset mid-operation abandons the operation with no write.

## Timing
- Let T be the accept edge.
- MTHI/MTLO: new value visible in T+1, no `busy`.
- MULT-class: `busy` in cycle T+1, write at end of T+1, `done` in T+1, result visible in T+2.
- DIV-class: DIV occupies T+1..T+32, FIX is T+33 with `done`, result visible in T+34, `busy` for 33 cycles.
- `read_req` in the cycle after `done` sees the new value.
- `stall` is combinational from `start`/`read_req`/state and has no register delay.

## Configuration
- `MULDIV_MADD_EN` defined: MADD/MADDU/MSUB/MSUBU behave as above.
- Undefined: those four ops are accepted in IDLE, pulse `illegal` in T+1, do not enter MUL, and leave HI/LO unchanged. The accumulate adder is not synthesized.

## Structure
- `signals` package gains `muldiv_op_t` (4-bit enum) and `muldiv_state_t`.
- The `selector` package is unchanged.
- Sub-module `divider_core`: unsigned restoring step datapath holding remainder/quotient shift registers, with inputs load/step and outputs quotient/remainder. Sign handling stays in `muldiv_sequencer`.

## Test plan
- MULT 0xFFFF_FFFF x 2: hi=0xFFFF_FFFF, lo=0xFFFF_FFFE, `done` at T+1. MULTU with the same operands gives hi=1, lo=0xFFFF_FFFE.
- DIV -7 / 2: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF, `done` exactly at T+33, `busy` high for 33 cycles.
- DIVU 5 / 0: hi=5, lo=0xFFFF_FFFF. DIV 0x8000_0000 / -1: lo=0x8000_0000, hi=0.
- MADD with hi:lo=0xFFFF_FFFF_FFFF_FFFF, operands 1 x 1: hi=lo=0 (wrap). With the macro undefined, the same op gives an `illegal` pulse and HI/LO unchanged.
- `read_req` at T+5 of a DIV: `stall`=1 until FIX, then 0 in T+34. A second `start` during DIV is held and accepted at T+34.
- `flush` at T+10 of a DIV: IDLE at T+11, no `done`, HI/LO keep prior values. `rst_n` low mid-MUL: hi=lo=0 immediately.
